// File: rtl/r_format_pkg.sv
// Shared R-format encodings: opcode, funct codes and the ALU_operation map
// that the execute stage decodes.
package r_format_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;

   localparam logic [5:0] FUNCT_SLL = 6'h00;
   localparam logic [5:0] FUNCT_SRL = 6'h02;
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_XOR = 6'h26;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_NOR = 4'b0101,
      ALU_SLT = 4'b0110,
      ALU_SLL = 4'b0111,
      ALU_SRL = 4'b1000
   } alu_op_e;

endpackage

// File: rtl/r_format_funct_decoder.sv
// Combinational opcode/funct decode; anything outside the supported R-format
// set reports legal = 0 and ALU_ADD as a don't-care operation.
module r_format_funct_decoder
   import r_format_pkg::*;
(
   input  logic [31:0] instruction,
   output logic [3:0]  alu_operation,
   output logic        legal
);

   alu_op_e alu_op;

   always_comb begin
      legal  = 1'b0;
      alu_op = ALU_ADD;
      if (instruction[31:26] == OPC_RTYPE) begin
         legal = 1'b1;
         case (instruction[5:0])
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_XOR: alu_op = ALU_XOR;
            FUNCT_NOR: alu_op = ALU_NOR;
            FUNCT_SLT: alu_op = ALU_SLT;
            FUNCT_SLL: alu_op = ALU_SLL;
            FUNCT_SRL: alu_op = ALU_SRL;
            default:   legal  = 1'b0;
         endcase
      end
   end

   assign alu_operation = alu_op;

endmodule

// File: rtl/r_format_decode_stage.sv
// R-format decode stage: valid/ready output register, pending-write scoreboard
// for RAW stalls, and a saturating illegal-instruction counter.
module r_format_decode_stage
   import r_format_pkg::*;
#(
   parameter int COUNT_W  = 16,
   parameter int NUM_REGS = 32
) (
   input  logic               clk,
   input  logic               reset_input,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [31:0]        instruction,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4:0]         rs_address,
   output logic [4:0]         rt_address,
   output logic [4:0]         rd_address,
   output logic [4:0]         shamt,
   output logic [3:0]         ALU_operation,
   output logic               write_enabled,
   input  logic               wb_valid,
   input  logic [4:0]         wb_address,
   output logic               illegal,
   output logic [COUNT_W-1:0] illegal_count
);

   logic [4:0] rs_in, rt_in, rd_in, sh_in;
   logic [3:0] alu_in;
   logic       legal, hazard, accept;

   logic                out_valid_q, out_valid_d;
   logic [4:0]          rs_address_q, rs_address_d;
   logic [4:0]          rt_address_q, rt_address_d;
   logic [4:0]          rd_address_q, rd_address_d;
   logic [4:0]          shamt_q, shamt_d;
   logic [3:0]          alu_operation_q, alu_operation_d;
   logic                write_enabled_q, write_enabled_d;
   logic                illegal_q, illegal_d;
   logic [COUNT_W-1:0]  illegal_count_q, illegal_count_d;
   logic [NUM_REGS-1:0] pending_q, pending_d;

   assign rs_in = instruction[25:21];
   assign rt_in = instruction[20:16];
   assign rd_in = instruction[15:11];
   assign sh_in = instruction[10:6];

   r_format_funct_decoder u_funct_decoder (
      .instruction   (instruction),
      .alu_operation (alu_in),
      .legal         (legal)
   );

   // Registered bitmap only: a write-back in this cycle releases the stall next cycle.
   assign hazard = instr_valid && legal &&
                   (((rs_in != 5'd0) && pending_q[rs_in]) ||
                    ((rt_in != 5'd0) && pending_q[rt_in]));

   assign instr_ready = reset_input && (!out_valid_q || out_ready) && !hazard;
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      out_valid_d     = out_valid_q;
      rs_address_d    = rs_address_q;
      rt_address_d    = rt_address_q;
      rd_address_d    = rd_address_q;
      shamt_d         = shamt_q;
      alu_operation_d = alu_operation_q;
      write_enabled_d = write_enabled_q;
      illegal_d       = accept && !legal;
      illegal_count_d = illegal_count_q;
      pending_d       = pending_q;

      if (accept && legal) begin
         out_valid_d     = 1'b1;
         rs_address_d    = rs_in;
         rt_address_d    = rt_in;
         rd_address_d    = rd_in;
         shamt_d         = sh_in;
         alu_operation_d = alu_in;
         write_enabled_d = (rd_in != 5'd0);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (illegal_d && (illegal_count_q != {COUNT_W{1'b1}}))
         illegal_count_d = illegal_count_q + COUNT_W'(1);

      // Clear before set so a same-cycle retire and re-claim leaves the bit set.
      if (wb_valid)
         pending_d[wb_address] = 1'b0;
      if (accept && legal && (rd_in != 5'd0))
         pending_d[rd_in] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_input) begin
      if (!reset_input) begin
         out_valid_q     <= 1'b0;
         rs_address_q    <= 5'd0;
         rt_address_q    <= 5'd0;
         rd_address_q    <= 5'd0;
         shamt_q         <= 5'd0;
         alu_operation_q <= 4'd0;
         write_enabled_q <= 1'b0;
         illegal_q       <= 1'b0;
         illegal_count_q <= '0;
         pending_q       <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         rs_address_q    <= rs_address_d;
         rt_address_q    <= rt_address_d;
         rd_address_q    <= rd_address_d;
         shamt_q         <= shamt_d;
         alu_operation_q <= alu_operation_d;
         write_enabled_q <= write_enabled_d;
         illegal_q       <= illegal_d;
         illegal_count_q <= illegal_count_d;
         pending_q       <= pending_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign rs_address    = rs_address_q;
   assign rt_address    = rt_address_q;
   assign rd_address    = rd_address_q;
   assign shamt         = shamt_q;
   assign ALU_operation = alu_operation_q;
   assign write_enabled = write_enabled_q;
   assign illegal       = illegal_q;
   assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_r_format_decode_stage.sv
// Directed bench for r_format_decode_stage: a vector table over the decode
// map plus hand-written stall, backpressure, saturation and reset sequences.
module tb_r_format_decode_stage;

   logic        clk;
   logic        reset_input;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  rs_address, rt_address, rd_address, shamt;
   logic [3:0]  ALU_operation;
   logic        write_enabled;
   logic        wb_valid;
   logic [4:0]  wb_address;
   logic        illegal;
   logic [15:0] illegal_count;

   int checks   = 0;
   int failures = 0;
   int exp_count = 0;

   r_format_decode_stage #(.COUNT_W(16), .NUM_REGS(32)) dut (
      .clk           (clk),
      .reset_input   (reset_input),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instruction   (instruction),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .rs_address    (rs_address),
      .rt_address    (rt_address),
      .rd_address    (rd_address),
      .shamt         (shamt),
      .ALU_operation (ALU_operation),
      .write_enabled (write_enabled),
      .wb_valid      (wb_valid),
      .wb_address    (wb_address),
      .illegal       (illegal),
      .illegal_count (illegal_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic [4:0] rs, rt, rd, sh;
      logic [5:0] fn;
      logic       legal;
      logic [3:0] alu;
      logic       we;
   } vec_t;

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn);
      return {op, rs, rt, rd, sh, fn};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_valid = 1'b0;
      wb_valid    = 1'b0;
   endtask

   task automatic retire(input logic [4:0] r);
      idle();
      wb_valid   = 1'b1;
      wb_address = r;
      step();
      wb_valid   = 1'b0;
   endtask

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{6'h00, 5'd1,  5'd3,  5'd2,  5'd0,  6'h20, 1'b1, 4'b0000, 1'b1};
      vecs[1]  = '{6'h00, 5'd4,  5'd5,  5'd6,  5'd0,  6'h22, 1'b1, 4'b0001, 1'b1};
      vecs[2]  = '{6'h00, 5'd7,  5'd8,  5'd9,  5'd0,  6'h24, 1'b1, 4'b0010, 1'b1};
      vecs[3]  = '{6'h00, 5'd10, 5'd11, 5'd12, 5'd0,  6'h25, 1'b1, 4'b0011, 1'b1};
      vecs[4]  = '{6'h00, 5'd13, 5'd14, 5'd15, 5'd0,  6'h26, 1'b1, 4'b0100, 1'b1};
      vecs[5]  = '{6'h00, 5'd16, 5'd17, 5'd18, 5'd0,  6'h27, 1'b1, 4'b0101, 1'b1};
      vecs[6]  = '{6'h00, 5'd19, 5'd20, 5'd21, 5'd0,  6'h2A, 1'b1, 4'b0110, 1'b1};
      vecs[7]  = '{6'h00, 5'd0,  5'd22, 5'd23, 5'd4,  6'h00, 1'b1, 4'b0111, 1'b1};
      vecs[8]  = '{6'h00, 5'd0,  5'd24, 5'd31, 5'd31, 6'h02, 1'b1, 4'b1000, 1'b1};
      vecs[9]  = '{6'h00, 5'd25, 5'd26, 5'd0,  5'd0,  6'h20, 1'b1, 4'b0000, 1'b0};
      vecs[10] = '{6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h21, 1'b0, 4'b0000, 1'b0};
      vecs[11] = '{6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h3F, 1'b0, 4'b0000, 1'b0};
      vecs[12] = '{6'h08, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 1'b0, 4'b0000, 1'b0};
      vecs[13] = '{6'h23, 5'd4,  5'd5,  5'd6,  5'd0,  6'h00, 1'b0, 4'b0000, 1'b0};

      reset_input = 1'b0;
      instr_valid = 1'b0;
      instruction = 32'h0;
      out_ready   = 1'b1;
      wb_valid    = 1'b0;
      wb_address  = 5'd0;
      #2;
      chk("reset_ready", {31'd0, instr_ready}, 32'd0);
      step();
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_fields", {rs_address, rt_address, rd_address, shamt, ALU_operation, write_enabled},
          32'd0);
      chk("reset_illegal", {31'd0, illegal}, 32'd0);
      chk("reset_count", {16'd0, illegal_count}, 32'd0);
      reset_input = 1'b1;
      step();

      // Decode table; each legal destination is retired right after so no stalls carry over.
      for (int i = 0; i < 14; i++) begin
         instruction = mk(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].fn);
         instr_valid = 1'b1;
         #1;
         chk($sformatf("v%0d_ready", i), {31'd0, instr_ready}, 32'd1);
         step();
         if (!vecs[i].legal) exp_count++;
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].legal});
         chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, !vecs[i].legal});
         chk($sformatf("v%0d_count", i), {16'd0, illegal_count}, exp_count);
         if (vecs[i].legal) begin
            chk($sformatf("v%0d_alu", i), {28'd0, ALU_operation}, {28'd0, vecs[i].alu});
            chk($sformatf("v%0d_we", i), {31'd0, write_enabled}, {31'd0, vecs[i].we});
            chk($sformatf("v%0d_regs", i), {12'd0, rs_address, rt_address, rd_address, shamt},
                {12'd0, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh});
         end
         retire(vecs[i].rd);
         chk($sformatf("v%0d_illegal_pulse_end", i), {31'd0, illegal}, 32'd0);
         chk($sformatf("v%0d_out_drain", i), {31'd0, out_valid}, 32'd0);
      end

      // RAW stall on $2 released only the cycle after write-back.
      instruction = 32'h00231020;
      instr_valid = 1'b1;
      step();
      chk("add_out", {26'd0, out_valid, rs_address, rt_address, rd_address, ALU_operation, write_enabled},
          {26'd0, 1'b1, 5'd1, 5'd3, 5'd2, 4'b0000, 1'b1});
      instruction = 32'h00412022;
      #1;
      chk("sub_stalled", {31'd0, instr_ready}, 32'd0);
      step();
      chk("add_drained", {31'd0, out_valid}, 32'd0);
      chk("sub_still_stalled", {31'd0, instr_ready}, 32'd0);
      wb_valid   = 1'b1;
      wb_address = 5'd2;
      #1;
      chk("no_wb_bypass", {31'd0, instr_ready}, 32'd0);
      step();
      wb_valid = 1'b0;
      #1;
      chk("sub_released", {31'd0, instr_ready}, 32'd1);
      step();
      chk("sub_out", {22'd0, out_valid, rs_address, rt_address, rd_address, ALU_operation},
          {22'd0, 1'b1, 5'd2, 5'd1, 5'd4, 4'b0001});
      retire(5'd4);

      // Same-cycle set and retire of $6: the set must win.
      instruction = mk(6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h20);
      instr_valid = 1'b1;
      wb_valid    = 1'b1;
      wb_address  = 5'd6;
      step();
      wb_valid    = 1'b0;
      instruction = mk(6'h00, 5'd6, 5'd1, 5'd10, 5'd0, 6'h22);
      #1;
      chk("set_wins_stall", {31'd0, instr_ready}, 32'd0);
      retire(5'd6);

      // Backpressure: output held for 5 cycles, queued OR loads when out_ready rises.
      out_ready   = 1'b0;
      instruction = mk(6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20);
      instr_valid = 1'b1;
      step();
      instruction = mk(6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h25);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_ready_c%0d", c), {31'd0, instr_ready}, 32'd0);
         chk($sformatf("bp_hold_c%0d", c), {22'd0, out_valid, rs_address, rt_address, rd_address, ALU_operation},
             {22'd0, 1'b1, 5'd1, 5'd2, 5'd7, 4'b0000});
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, instr_ready}, 32'd1);
      step();
      chk("bp_or_out", {27'd0, out_valid, rd_address, ALU_operation} >> 0,
          {27'd0, 1'b1, 5'd8, 4'b0011});
      retire(5'd7);
      retire(5'd8);

      // Write to $0 claims nothing; a reader of $0 proceeds.
      instruction = 32'h00220024;
      instr_valid = 1'b1;
      step();
      chk("and_r0_out", {24'd0, out_valid, rd_address, ALU_operation, write_enabled},
          {24'd0, 1'b1, 5'd0, 4'b0010, 1'b0});
      instruction = mk(6'h00, 5'd0, 5'd0, 5'd3, 5'd0, 6'h20);
      #1;
      chk("r0_reader_ready", {31'd0, instr_ready}, 32'd1);
      step();
      chk("r0_reader_out", {26'd0, out_valid, rd_address}, {26'd0, 1'b1, 5'd3});
      retire(5'd3);

      // Illegal opcode, then saturation of the counter.
      instruction = 32'h20010005;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      exp_count++;
      chk("illegal_pulse", {30'd0, illegal, out_valid}, {30'd0, 1'b1, 1'b0});
      chk("illegal_count", {16'd0, illegal_count}, exp_count);
      step();
      chk("illegal_one_cycle", {31'd0, illegal}, 32'd0);
      instr_valid = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      instr_valid = 1'b0;
      step();
      chk("count_saturated", {16'd0, illegal_count}, 32'h0000FFFF);

      // Async reset mid-stream with pending[5] and a held output.
      out_ready   = 1'b0;
      instruction = mk(6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20);
      instr_valid = 1'b1;
      step();
      chk("pre_reset_held", {26'd0, out_valid, rd_address}, {26'd0, 1'b1, 5'd5});
      #2;
      reset_input = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_count", {16'd0, illegal_count}, 32'd0);
      chk("reset_blocks_accept", {31'd0, instr_ready}, 32'd0);
      step();
      reset_input = 1'b1;
      out_ready   = 1'b1;
      instruction = mk(6'h00, 5'd5, 5'd5, 5'd9, 5'd0, 6'h20);
      #1;
      chk("post_reset_no_stall", {31'd0, instr_ready}, 32'd1);
      step();
      chk("post_reset_out", {21'd0, out_valid, rs_address, rt_address, rd_address},
          {21'd0, 1'b1, 5'd5, 5'd5, 5'd9});
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
